// File: rtl/mem_dma_engine_if.sv
// mem_dma_engine_if: data-memory bus between the DMA engine (master) and the dual-read-port memory (slave)
interface mem_dma_engine_if #(parameter int N = 32, parameter int AW = 5);
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_addr2;
  logic [N-1:0]  mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [N-1:0]  mem_rdata;
  logic [N-1:0]  mem_rdata2;
  modport master (
    output mem_addr, mem_addr2, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_rdata2
  );
  modport slave (
    input  mem_addr, mem_addr2, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_rdata2
  );
endinterface

// File: rtl/mem_dma_engine.sv
// mem_dma_engine: sequences block COPY, FILL and SUM commands against the dual-read-port data memory
module mem_dma_engine #(
  parameter int N  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [N-1:0]  fill_val,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  mem_dma_engine_if.master mem
);
  typedef enum logic [2:0] {IDLE, RD, WR, SUMRD, FIN} state_t;
  localparam logic [1:0]    OP_COPY = 2'b00;
  localparam logic [1:0]    OP_FILL = 2'b01;
  localparam logic [1:0]    OP_SUM  = 2'b10;
  localparam logic [1:0]    OP_RSV  = 2'b11;
  localparam logic [AW:0]   ONE     = 1;
  localparam logic [AW:0]   TWO     = 2;
  localparam logic [AW-1:0] A1      = 1;
  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [AW:0]   len_q, len_d, i_q, i_d;
  logic [N-1:0]  fill_q, fill_d, acc_q, acc_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [N-1:0]  result_q, result_d;
  logic [AW-1:0] addr_q, addr_d, addr2_q, addr2_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic          read_q, read_d, write_q, write_d;
  logic [AW:0]   i_n1, i_n2, rem;
  logic [N-1:0]  add;
  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_addr2 = addr2_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_read  = read_q;
  assign mem.mem_write = write_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    fill_d   = fill_q;
    i_d      = i_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    addr_d   = addr_q;
    addr2_d  = addr2_q;
    wdata_d  = wdata_q;
    read_d   = read_q;
    write_d  = write_q;
    i_n1     = i_q + ONE;
    i_n2     = i_q + TWO;
    rem      = len_q - i_q;
    // a lone trailing word of an odd-length SUM ignores the second read port
    add      = mem.mem_rdata + (rem == ONE ? '0 : mem.mem_rdata2);
    case (state_q)
      IDLE: if (start) begin
        op_d   = op;
        src_d  = src;
        dst_d  = dst;
        len_d  = len;
        fill_d = fill_val;
        i_d    = '0;
        acc_d  = '0;
        if (len == '0 || op == OP_RSV) begin
          state_d  = FIN;
          done_d   = 1'b1;
          result_d = op == OP_SUM ? '0 : result_q;
        end else begin
          state_d = op == OP_COPY ? RD : op == OP_FILL ? WR : SUMRD;
          busy_d  = 1'b1;
          read_d  = op != OP_FILL;
          write_d = op == OP_FILL;
          addr_d  = op == OP_FILL ? dst : src;
          addr2_d = op == OP_SUM ? src + A1 : '0;
          wdata_d = op == OP_FILL ? fill_val : wdata_q;
        end
      end
      RD: begin
        state_d = WR;
        read_d  = 1'b0;
        write_d = 1'b1;
        wdata_d = mem.mem_rdata;
        addr_d  = dst_q + i_q[AW-1:0];
      end
      WR: begin
        i_d = i_n1;
        if (i_n1 == len_q) begin
          state_d = FIN;
          write_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = op_q == OP_COPY ? RD : WR;
          read_d  = op_q == OP_COPY;
          write_d = op_q != OP_COPY;
          addr_d  = op_q == OP_COPY ? src_q + i_n1[AW-1:0] : dst_q + i_n1[AW-1:0];
        end
      end
      SUMRD: begin
        acc_d = acc_q + add;
        i_d   = i_n2;
        if (rem <= TWO) begin
          state_d  = FIN;
          read_d   = 1'b0;
          addr2_d  = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = acc_q + add;
        end else begin
          addr_d  = src_q + i_n2[AW-1:0];
          addr2_d = src_q + i_n2[AW-1:0] + A1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      i_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      addr_q   <= '0;
      addr2_q  <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      i_q      <= i_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      addr2_q  <= addr2_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
    end
  end
endmodule

// File: tb/tb_mem_dma_engine.sv
// tb_mem_dma_engine: directed table, reset-abort sequence and random commands against a block-level memory model
module tb_mem_dma_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [4:0]  src = '0, dst = '0;
  logic [5:0]  len = '0;
  logic [31:0] fill_val = '0;
  logic        busy, done;
  logic [31:0] result;
  logic        load = 1'b0;
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic [31:0] res_exp = '0;
  int checks = 0, errors = 0;
  int both_cnt = 0, acc_cnt = 0, addr2_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  src, dst;
    logic [5:0]  len;
    logic [31:0] fill;
    bit          garb;
    int          lat;
    bit          chk_res;
    logic [31:0] res;
  } vec_t;
  vec_t tab [12];

  mem_dma_engine_if #(.N(32), .AW(5)) bus ();

  mem_dma_engine #(.N(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst), .len(len),
    .fill_val(fill_val), .busy(busy), .done(done), .result(result), .mem(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pre(input int k);
    return k < 4 ? 32'(k + 1) : k == 30 ? 32'd60 : 32'd0;
  endfunction

  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus.mem_rdata2 = mem[bus.mem_addr2];
  always @(posedge clk) begin
    if (load) for (int k = 0; k < 32; k++) mem[k] <= pre(k);
    else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  always @(negedge clk) begin
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if (bus.mem_read || bus.mem_write) acc_cnt++;
    if (!bus.mem_read && bus.mem_addr2 != '0) addr2_bad++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_load();
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    for (int k = 0; k < 32; k++) ref_mem[k] = pre(k);
  endtask

  // block-level semantics: whole-command effect on memory, result and latency
  task automatic model(input vec_t v, output int lat);
    int eff;
    logic [31:0] s;
    eff = v.op == 2'b11 ? 0 : int'(v.len);
    s = '0;
    lat = 1;
    case (v.op)
      2'b00: begin
        for (int k = 0; k < eff; k++) ref_mem[(int'(v.dst) + k) % 32] = ref_mem[(int'(v.src) + k) % 32];
        lat = 2 * eff + 1;
      end
      2'b01: begin
        for (int k = 0; k < eff; k++) ref_mem[(int'(v.dst) + k) % 32] = v.fill;
        lat = eff + 1;
      end
      2'b10: begin
        for (int k = 0; k < eff; k++) s = s + ref_mem[(int'(v.src) + k) % 32];
        res_exp = s;
        lat = (eff + 1) / 2 + 1;
      end
      default: lat = 1;
    endcase
  endtask

  task automatic mem_cmp(input string name);
    int bad;
    bad = -1;
    for (int k = 31; k >= 0; k--) if (mem[k] !== ref_mem[k]) bad = k;
    chk(name, 64'(bad < 0 ? 32'd0 : mem[bad]), 64'(bad < 0 ? 32'd0 : ref_mem[bad]));
  endtask

  task automatic run(input vec_t v, input bit use_tab);
    int lat, cyc, busy_n, acc0;
    bit busy_at_done;
    model(v, lat);
    acc0 = acc_cnt;
    @(negedge clk);
    op = v.op; src = v.src; dst = v.dst; len = v.len; fill_val = v.fill; start = 1'b1;
    @(posedge clk);
    #1;
    start = v.garb ? 1'($urandom_range(0, 1)) : 1'b0;
    if (v.garb) begin
      op = 2'($urandom); src = 5'($urandom); dst = 5'($urandom);
      len = 6'($urandom_range(0, 32)); fill_val = $urandom;
    end
    cyc = 1;
    busy_n = 0;
    while (!done && cyc < 200) begin
      busy_n += int'(busy);
      @(posedge clk);
      #1;
      cyc++;
      if (v.garb) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    busy_at_done = busy;
    chk("done_seen", 64'(done), 64'd1);
    chk("latency", 64'(cyc), 64'(lat));
    if (use_tab) chk("latency_tab", 64'(cyc), 64'(v.lat));
    chk("busy_cycles", 64'(busy_n), 64'(lat - 1));
    chk("busy_in_fin", 64'(busy_at_done), 64'd0);
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
    mem_cmp("memory");
    chk("result", 64'(result), 64'(res_exp));
    if (use_tab && v.chk_res) chk("result_tab", 64'(result), 64'(v.res));
    if (v.op == 2'b11 || v.len == '0) chk("no_access", 64'(acc_cnt - acc0), 64'd0);
  endtask

  initial begin
    vec_t v;
    bit seen;
    tab[0]  = '{2'b00, 5'd0,  5'd8,  6'd4,  32'h0,        1'b0, 9,  1'b0, 32'h0};
    tab[1]  = '{2'b10, 5'd0,  5'd0,  6'd3,  32'h0,        1'b0, 3,  1'b1, 32'd6};
    tab[2]  = '{2'b10, 5'd30, 5'd0,  6'd2,  32'h0,        1'b0, 2,  1'b1, 32'd60};
    tab[3]  = '{2'b00, 5'd4,  5'd20, 6'd0,  32'h0,        1'b0, 1,  1'b1, 32'd60};
    tab[4]  = '{2'b01, 5'd0,  5'd30, 6'd4,  32'hA5,       1'b0, 5,  1'b0, 32'h0};
    tab[5]  = '{2'b10, 5'd30, 5'd0,  6'd4,  32'h0,        1'b0, 3,  1'b1, 32'h294};
    tab[6]  = '{2'b00, 5'd8,  5'd9,  6'd3,  32'h0,        1'b1, 7,  1'b0, 32'h0};
    tab[7]  = '{2'b10, 5'd8,  5'd0,  6'd4,  32'h0,        1'b0, 3,  1'b1, 32'd4};
    tab[8]  = '{2'b11, 5'd1,  5'd2,  6'd5,  32'h7,        1'b0, 1,  1'b1, 32'd4};
    tab[9]  = '{2'b01, 5'd3,  5'd0,  6'd32, 32'hFFFFFFFF, 1'b1, 33, 1'b0, 32'h0};
    tab[10] = '{2'b10, 5'd5,  5'd0,  6'd32, 32'h0,        1'b0, 17, 1'b1, 32'hFFFFFFE0};
    tab[11] = '{2'b10, 5'd7,  5'd0,  6'd1,  32'h0,        1'b0, 2,  1'b1, 32'hFFFFFFFF};
    load = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    load = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 32; k++) ref_mem[k] = pre(k);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_addr2", 64'(bus.mem_addr2), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_read", 64'(bus.mem_read), 64'd0);
    chk("rst_write", 64'(bus.mem_write), 64'd0);
    for (int t = 0; t < 12; t++) run(tab[t], 1'b1);
    do_load();
    @(negedge clk);
    op = 2'b00; src = 5'd0; dst = 5'd8; len = 6'd4; start = 1'b1;
    seen = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) begin
      seen |= done;
      @(posedge clk);
      #1;
    end
    seen |= done;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ref_mem[8] = 32'd1;
    res_exp = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_read", 64'(bus.mem_read), 64'd0);
    chk("abort_write", 64'(bus.mem_write), 64'd0);
    chk("abort_addr", 64'(bus.mem_addr), 64'd0);
    chk("abort_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    repeat (6) begin
      seen |= done;
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    mem_cmp("abort_memory");
    for (int t = 0; t < 40; t++) begin
      v.op = 2'($urandom); v.src = 5'($urandom); v.dst = 5'($urandom);
      v.len = 6'($urandom_range(0, 32)); v.fill = $urandom;
      v.garb = 1'($urandom_range(0, 1)); v.lat = 0; v.chk_res = 1'b0; v.res = '0;
      run(v, 1'b0);
    end
    chk("rw_exclusive", 64'(both_cnt), 64'd0);
    chk("addr2_idle_zero", 64'(addr2_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
